// File: rtl/clock_time_sched.sv
// Time-of-day keeper for the VGA clock with frame-synchronous display snapshot.
// Latency: display/hour_tick/update_pulse follow frame_start by 1 clk; load_err follows an accept by 1 clk.
// Backpressure: load_ready is low from an accepted load until the commit that shows it, so at most one load per frame.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   freeze                     (only with TIME_FREEZE_EN) holds the prescaler while high
//   frame_start                1-cycle pulse at vertical blanking; triggers a display commit
//   load_valid/load_ready      time-load handshake; load_hour/load_minute/load_second carry the word
//   load_err                   1-cycle pulse after an out-of-range word was accepted and dropped
//   hour_disp/minute_disp/second_disp/hour_tick   committed display snapshot
//   update_pulse               1-cycle pulse whenever the snapshot is refreshed
//
// Optional feature macro: TIME_FREEZE_EN (adds the freeze input).

module clock_time_sched #(
    parameter int TICKS_PER_SEC = 40_000_000
) (
    input  logic       clk,
    input  logic       reset,
`ifdef TIME_FREEZE_EN
    input  logic       freeze,
`endif
    input  logic       frame_start,
    input  logic       load_valid,
    input  logic [4:0] load_hour,
    input  logic [5:0] load_minute,
    input  logic [5:0] load_second,
    output logic       load_ready,
    output logic       load_err,
    output logic [4:0] hour_disp,
    output logic [5:0] minute_disp,
    output logic [5:0] second_disp,
    output logic [5:0] hour_tick,
    output logic       update_pulse
);

    // Prescaler width; a degenerate 1-cycle tick still needs one bit of state.
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Live (running) time; the display registers only sample it at frame start.
    logic [4:0]    hour;
    logic [5:0]    minute;
    logic [5:0]    second;
    logic [PW-1:0] presc;

    logic accept;
    logic in_range;
    logic load_ok;
    logic run;
    logic presc_wrap;
    logic tick;

    // ------------------------------------------------------------------
    // Handshake and range check
    // ------------------------------------------------------------------
    always_comb begin
        accept   = load_valid & load_ready;
        in_range = (load_hour <= 5'd11) && (load_minute <= 6'd59) && (load_second <= 6'd59);
        load_ok  = accept & in_range;
    end

    // ------------------------------------------------------------------
    // Tick generation. A successful load restarts the prescaler and
    // swallows any tick that would have landed in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
`ifdef TIME_FREEZE_EN
        run = ~freeze;
`else
        run = 1'b1;
`endif
        presc_wrap = (presc == PRE_MAX);
        tick       = run & presc_wrap & ~load_ok;
    end

    // ------------------------------------------------------------------
    // Load scheduler: IDLE accepts, PEND waits for the frame that will
    // show the loaded time, COMMIT is the one-cycle hand-back to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_ok) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (frame_start) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Handshake outputs. load_ready is registered so it stays low while
    // reset is held and rises one cycle after reset releases.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            load_ready <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            load_ready <= (state_nxt == IDLE);
            load_err   <= accept & ~in_range;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (load_ok) begin
            presc <= '0;
        end else if (run) begin
            if (presc_wrap) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Live time: load has priority over the seconds carry chain.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hour   <= '0;
            minute <= '0;
            second <= '0;
        end else if (load_ok) begin
            hour   <= load_hour;
            minute <= load_minute;
            second <= load_second;
        end else if (tick) begin
            if (second == 6'd59) begin
                second <= '0;
                if (minute == 6'd59) begin
                    minute <= '0;
                    if (hour == 5'd11) begin
                        hour <= '0;
                    end else begin
                        hour <= hour + 5'd1;
                    end
                end else begin
                    minute <= minute + 6'd1;
                end
            end else begin
                second <= second + 6'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display snapshot. Samples the live registers before this cycle's
    // load/tick lands, so a load accepted on a frame_start cycle shows
    // up only at the following frame. hour_tick places the hour hand
    // between hour marks: five ticks per hour plus one per 12 minutes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hour_disp    <= '0;
            minute_disp  <= '0;
            second_disp  <= '0;
            hour_tick    <= '0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= frame_start;
            if (frame_start) begin
                hour_disp   <= hour;
                minute_disp <= minute;
                second_disp <= second;
                hour_tick   <= 6'(({3'b000, hour} * 8'd5) + ({2'b00, minute} / 8'd12));
            end
        end
    end

endmodule

// File: tb/tb_clock_time_sched.sv
module tb_clock_time_sched;

    localparam int TPS = 4;
    localparam int DAY = 12 * 3600;

    logic       clk = 1'b0;
    logic       reset;
`ifdef TIME_FREEZE_EN
    logic       freeze;
`endif
    logic       frame_start;
    logic       load_valid;
    logic [4:0] load_hour;
    logic [5:0] load_minute;
    logic [5:0] load_second;
    logic       load_ready;
    logic       load_err;
    logic [4:0] hour_disp;
    logic [5:0] minute_disp;
    logic [5:0] second_disp;
    logic [5:0] hour_tick;
    logic       update_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: time kept as seconds since 12 o'clock.
    int m_live  = 0;
    int m_pre   = 0;
    int m_disp  = 0;
    bit m_pulse = 0;
    bit m_err   = 0;
    bit m_ready = 0;
    bit m_waiting = 0;   // a load was accepted and awaits its frame
    bit m_hold    = 0;   // one-cycle lockout right after that frame

    clock_time_sched #(.TICKS_PER_SEC(TPS)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef TIME_FREEZE_EN
        .freeze       (freeze),
`endif
        .frame_start  (frame_start),
        .load_valid   (load_valid),
        .load_hour    (load_hour),
        .load_minute  (load_minute),
        .load_second  (load_second),
        .load_ready   (load_ready),
        .load_err     (load_err),
        .hour_disp    (hour_disp),
        .minute_disp  (minute_disp),
        .second_disp  (second_disp),
        .hour_tick    (hour_tick),
        .update_pulse (update_pulse)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_step();
        bit acc;
        bit ok;
        bit running;
        int h;
        int m;
        int s;
        if (reset) begin
            m_live = 0; m_pre = 0; m_disp = 0; m_pulse = 0; m_err = 0;
            m_ready = 0; m_waiting = 0; m_hold = 0;
            return;
        end
        h = int'(load_hour);
        m = int'(load_minute);
        s = int'(load_second);
        acc = load_valid && m_ready;
        ok  = (h < 12) && (m < 60) && (s < 60);
`ifdef TIME_FREEZE_EN
        running = !freeze;
`else
        running = 1'b1;
`endif
        m_pulse = frame_start;
        if (frame_start) m_disp = m_live;
        m_err = acc && !ok;
        if (m_hold) begin
            m_hold = 0;
        end else if (m_waiting) begin
            if (frame_start) begin
                m_waiting = 0;
                m_hold = 1;
            end
        end else if (acc && ok) begin
            m_waiting = 1;
        end
        m_ready = !m_waiting && !m_hold;
        if (acc && ok) begin
            m_live = h * 3600 + m * 60 + s;
            m_pre  = 0;
        end else if (running) begin
            if (m_pre == TPS - 1) begin
                m_pre  = 0;
                m_live = (m_live + 1) % DAY;
            end else begin
                m_pre = m_pre + 1;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("hour_disp",    32'(hour_disp),    32'(m_disp / 3600));
        check("minute_disp",  32'(minute_disp),  32'((m_disp / 60) % 60));
        check("second_disp",  32'(second_disp),  32'(m_disp % 60));
        check("hour_tick",    32'(hour_tick),    32'((m_disp / 3600) * 5 + ((m_disp / 60) % 60) / 12));
        check("update_pulse", 32'(update_pulse), 32'(m_pulse));
        check("load_err",     32'(load_err),     32'(m_err));
        check("load_ready",   32'(load_ready),   32'(m_ready));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    // Present a word and hold it until accepted; optionally pulse frame_start on the accept cycle.
    task automatic send(input int h, input int m, input int s, input bit with_frame);
        bit acc;
        load_hour   = 5'(h);
        load_minute = 6'(m);
        load_second = 6'(s);
        load_valid  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            acc = (load_ready === 1'b1);
            frame_start = acc && with_frame;
            cycle();
            frame_start = 1'b0;
            if (acc) begin
                load_valid = 1'b0;
                return;
            end
        end
        load_valid = 1'b0;
        check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit acc_now;
        int frozen_sec;
        reset = 1'b1; frame_start = 1'b0; load_valid = 1'b0;
        load_hour = '0; load_minute = '0; load_second = '0;
`ifdef TIME_FREEZE_EN
        freeze = 1'b0;
`endif
        cycle();
        cycle();
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_hour_tick", 32'(hour_tick), 32'd0);
        reset = 1'b0;
        cycle();
        check("ready_after_rst", 32'(load_ready), 32'd1);

        // Rollover 11:59:59 -> 0:00:00
        send(11, 59, 59, 0);
        frame();
        check("pre_roll_hour", 32'(hour_disp), 32'd11);
        check("pre_roll_sec", 32'(second_disp), 32'd59);
        idle(4);
        frame();
        check("roll_hour", 32'(hour_disp), 32'd0);
        check("roll_min", 32'(minute_disp), 32'd0);
        check("roll_sec", 32'(second_disp), 32'd0);
        check("roll_tick", 32'(hour_tick), 32'd0);
        check("roll_pulse", 32'(update_pulse), 32'd1);

        // Frame-synchronous commit plus backpressure while pending
        send(3, 30, 0, 0);
        load_hour = 5'd6; load_minute = 6'd15; load_second = 6'd0; load_valid = 1'b1;
        idle(2);
        check("bp_ready", 32'(load_ready), 32'd0);
        check("sync_hold_hour", 32'(hour_disp), 32'd0);
        frame();
        check("sync_hour", 32'(hour_disp), 32'd3);
        check("sync_min", 32'(minute_disp), 32'd30);
        check("sync_tick", 32'(hour_tick), 32'd17);

        // Collision: accept on the same cycle as frame_start
        send(6, 15, 0, 1);
        check("coll_old_hour", 32'(hour_disp), 32'd3);
        check("coll_old_min", 32'(minute_disp), 32'd30);
        idle(2);
        frame();
        check("coll_hour", 32'(hour_disp), 32'd6);
        check("coll_min", 32'(minute_disp), 32'd15);
        check("coll_tick", 32'(hour_tick), 32'd31);

        // Range check
        idle(2);
        send(12, 0, 0, 0);
        check("err_hour", 32'(load_err), 32'd1);
        check("err_ready", 32'(load_ready), 32'd1);
        cycle();
        check("err_pulse_end", 32'(load_err), 32'd0);
        send(5, 60, 0, 0);
        check("err_min", 32'(load_err), 32'd1);
        frame();
        check("err_keep_hour", 32'(hour_disp), 32'd6);
        check("err_keep_min", 32'(minute_disp), 32'd15);

        // Reset while a load is pending
        idle(2);
        send(2, 0, 0, 0);
        idle(1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        frame();
        check("rst_pend_hour", 32'(hour_disp), 32'd0);
        check("rst_pend_min", 32'(minute_disp), 32'd0);

`ifdef TIME_FREEZE_EN
        freeze = 1'b1;
        frame();
        frozen_sec = m_disp % 60;
        for (int k = 0; k < 4; k++) begin
            idle(4);
            frame();
            check("freeze_sec", 32'(second_disp), 32'(frozen_sec));
        end
        freeze = 1'b0;
        idle(5);
        frame();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            frame_start = ($urandom_range(0, 15) == 0);
            if (!load_valid && $urandom_range(0, 5) == 0) begin
                load_hour   = 5'($urandom_range(0, 13));
                load_minute = 6'($urandom_range(0, 61));
                load_second = 6'($urandom_range(0, 61));
                load_valid  = 1'b1;
            end
            acc_now = load_valid && (load_ready === 1'b1) && !reset;
            cycle();
            frame_start = 1'b0;
            reset = 1'b0;
            if (acc_now) load_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
